// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: OAM DMA sequencer states and fixed register addresses.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        GET,
        PUT
    } dma_state_e;

    localparam logic [15:0] NES_DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] NES_OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_arb.sv
// Shared CPU/memory bus owner: passes CPU traffic through when idle and runs the
// 256-byte sprite DMA (page -> OAM data port) while holding the CPU halted.
module oam_dma_arb
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = NES_DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = NES_OAM_DATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        dma_busy
);

    dma_state_e  state;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic        cyc_odd;
    logic        trigger;

    assign trigger   = cpu_we && (cpu_addr == DMA_REG_ADDR);
    assign cpu_rdata = mem_rdata;
    assign dma_busy  = (state != IDLE);

    // Sequencer; cyc_odd keeps toggling during DMA so GET always lands on even cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            page    <= 8'h00;
            idx     <= 8'h00;
            cyc_odd <= 1'b0;
        end else begin
            cyc_odd <= ~cyc_odd;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page  <= cpu_wdata;
                        idx   <= 8'h00;
                        state <= HALT;
                    end
                end
                HALT:  state <= cyc_odd ? GET : ALIGN;
                ALIGN: state <= GET;
                GET:   state <= PUT;
                PUT: begin
                    // idx wraps to 0 on the final transfer; page is never touched
                    idx   <= idx + 8'd1;
                    state <= (idx == 8'hFF) ? IDLE : GET;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus mux: CPU pass-through when idle, DMA owns the bus otherwise.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        cpu_rdy   = 1'b1;
        case (state)
            IDLE: ;
            HALT, ALIGN: begin
                cpu_rdy = 1'b0;
                mem_we  = 1'b0;
            end
            GET: begin
                cpu_rdy  = 1'b0;
                mem_we   = 1'b0;
                mem_addr = {page, idx};
            end
            PUT: begin
                cpu_rdy   = 1'b0;
                mem_we    = 1'b1;
                mem_addr  = OAM_DATA_ADDR;
                mem_wdata = mem_rdata;
            end
            default: begin
                cpu_rdy = 1'b0;
                mem_we  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/oam_dma_arb.md
# oam_dma_arb

Owns the shared CPU/memory bus and sequences NES sprite (OAM) DMA. A CPU write to the DMA register halts the CPU via `cpu_rdy`, alignment is inserted, then 256 bytes are copied from a CPU page to the PPU OAM data port by read/write pairs on the same bus. It sits between `cpu_duv_top`/`cpu_ref_top` and `mem_top`, inside the memory side of `tb_cpu_if`.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014: CPU write address that triggers DMA.
- `OAM_DATA_ADDR`, 16'h2004: destination address for every DMA write.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  16  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_we`  in  1  CPU write strobe.
- `cpu_rdata`  out  8  read data to CPU; always equals `mem_rdata`.
- `cpu_rdy`  out  1  CPU run enable; low freezes CPU, including its write strobes.
- `mem_addr`  out  16  address to memory.
- `mem_wdata`  out  8  write data to memory.
- `mem_we`  out  1  write strobe to memory.
- `mem_rdata`  in  8  synchronous memory read data; valid the cycle after its address.
- `dma_busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, HALT, ALIGN, GET, PUT.
- `cyc_odd`: free-running 1-bit toggle, 0 out of reset; toggles every cycle, including during DMA.
- IDLE:
  - Pass-through: `mem_addr=cpu_addr`, `mem_wdata=cpu_wdata`, `mem_we=cpu_we`, `cpu_rdy=1`.
  - Trigger: `cpu_we && cpu_addr==DMA_REG_ADDR`. The write still passes to memory.
  - On trigger: latch `page=cpu_wdata`, clear 8-bit `idx`, go to HALT.
- HALT (1 cycle): `cpu_rdy=0`, `mem_we=0`, `mem_addr=cpu_addr` (dummy read). Next state is ALIGN if `cyc_odd==0` (next cycle would be odd), else GET.
- ALIGN (1 cycle): same outputs as HALT, then go to GET.
- GET: `mem_addr={page,idx}`, `mem_we=0`, then go to PUT. GET always falls on an even cycle (`cyc_odd==0`).
- PUT: `mem_addr=OAM_DATA_ADDR`, `mem_we=1`, `mem_wdata=mem_rdata` (combinational; the byte read in GET).
  - If `idx==8'hFF`, go to IDLE.
  - Else increment `idx` and go to GET.
- In all non-IDLE states `cpu_rdy=0`, and CPU `cpu_we`/`cpu_addr` never reach memory. A trigger cannot occur during DMA.
- `idx` wraps only at the final transfer. No carry into `page`, so address range is exactly `{page,8'h00}`..`{page,8'hFF}`.
- Reset, including mid-DMA: state=IDLE, `idx=0`, `page=0`, `cyc_odd=0`, immediately (asynchronous). The partially copied OAM is left as is.

## Timing
- Reset values: `cpu_rdy=1`, `dma_busy=0`, `mem_we` and `mem_addr` follow pass-through, `cpu_rdata=mem_rdata`.
- Trigger sampled at edge T. HALT occupies cycle T+1; `cpu_rdy` goes low in T+1.
- Stall length (cycles with `cpu_rdy=0`):
  - 513 = HALT + 512, when HALT falls on an odd cycle.
  - 514 = HALT + ALIGN + 512, when HALT falls on an even cycle.
- `cpu_rdy` returns high in the cycle after the last PUT.
- 256 writes to `OAM_DATA_ADDR`, one every 2 cycles, data in `idx` order.
- Back-to-back DMA: a trigger in the first IDLE cycle after completion starts a new DMA normally.

## Structure
- Shared package `nes_bus_pkg` holds:
  - the `dma_state_e` enum (IDLE, HALT, ALIGN, GET, PUT);
  - `NES_DMA_REG_ADDR` and `NES_OAM_DATA_ADDR` constants, used as parameter defaults.
- Single flat module with one `always_ff` for state/`idx`/`page`/`cyc_odd` and one `always_comb` for the bus mux. No sub-module needed.
- Bench integration: instantiated between CPU and `mem_top` on both the DUV and reference sides, so both paths see identical stalls.

## Test plan
- Reset: hold `rst=1`, drive `cpu_we=1` at `16'h4014` -> `dma_busy=0`, `cpu_rdy=1`, outputs pass through. Release reset -> no DMA starts until a fresh trigger.
- Even-aligned DMA: preload `16'h0200+i = i^8'h5A`, write `8'h02` to `16'h4014` with HALT on an odd cycle -> 513 stall cycles, 256 writes to `16'h2004` with data `i^8'h5A` for i=0..255, in order.
- Odd-aligned DMA: same, with the trigger one cycle later -> exactly one ALIGN cycle, 514 stall cycles, every GET on `cyc_odd==0`.
- Page boundary: page `8'hFF` -> reads `16'hFF00`..`16'hFFFF` only, no wrap into `16'h0000`; `idx` returns to 0.
- Reset mid-DMA: assert `rst` after 100 PUTs -> `cpu_rdy=1` and `mem_we` follows `cpu_we` immediately, no further writes to `16'h2004`. A new trigger restarts from `idx=0`.
- Non-trigger traffic: CPU writes to `16'h4013`/`16'h4015` and reads of `16'h4014` -> no DMA, `cpu_rdy` stays 1.
